muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MIPS150 processor. It executes MULT, MULTU, DIV and DIVU on two 32-bit operands and holds the results in architectural HI/LO registers. It runs beside the single-cycle ALU in the execute stage and takes the same A/B operand buses. The datapath stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A`  in  32  multiplicand or dividend.
- `B`  in  32  multiplier or divisor.
- `mthi`  in  1  write `wdata` to HI (MTHI).
- `mtlo`  in  1  write `wdata` to LO (MTLO).
- `wdata`  in  32  data for MTHI/MTLO.
- `busy`  out  1  operation in progress; the datapath must stall MFHI/MFLO/MULT/DIV while high.
- `done`  out  1  one-cycle pulse: HI/LO were updated this cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE: accept work.
  - CALC: 32 iterations.
  - FIX: sign correction and result write.
  - DONE: one-cycle acknowledge. The unit is already able to accept work in this state.
- Transitions:
  - IDLE->CALC on `start`.
  - CALC->FIX when the 5-bit iteration counter reaches 31.
  - FIX->DONE.
  - DONE->CALC if `start`, else DONE->IDLE.
- Operand load at the start edge:
  - Signed ops (MULT, DIV) store |A| and |B| as 32-bit magnitudes. |0x80000000| = 0x80000000, treated as unsigned.
  - Signed ops also latch `neg_q = A[31]^B[31]` and `neg_r = A[31]`.
  - Unsigned ops store A and B unchanged, with both sign flags cleared.
- Multiply:
  - Radix-2 shift-add on a 64-bit accumulator {P_hi, P_lo}, one multiplier bit per cycle, LSB first.
  - The 33-bit add keeps the carry.
  - In FIX: if `neg_q`, {hi,lo} = two's-complement negation of the 64-bit product; otherwise {hi,lo} = product.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Each cycle: shift {R,Q} left 1, trial-subtract the divisor from the 33-bit remainder, restore on borrow.
  - In FIX: lo = `neg_q` ? −Q : Q; hi = `neg_r` ? −R : R. The remainder takes the sign of the dividend.
- Divide by zero (B = 0, signed or unsigned): lo = 32'hFFFF_FFFF, hi = A as originally presented. Full latency still applies; no exception is raised.
- Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives lo = 0x8000_0000, hi = 0 (mod 2^32 wrap, no trap).
- MTHI/MTLO:
  - Take effect only when state is IDLE or DONE; ignored while `busy`.
  - If `start` and an mt write occur in the same cycle, the write happens and is later overwritten by the result.
- `start` while in CALC or FIX is ignored and is not queued.

## Timing
- Reset (async, `rst_n` = 0): state = IDLE; `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0. All internal registers and the counter are cleared.
- Reset mid-operation aborts immediately. HI/LO become 0 and the operation is not completed after release.
- Let E0 be the edge that samples `start`:
  - Iterations run on E1..E32.
  - FIX on E33 writes hi/lo.
  - `done` = 1 and new hi/lo are visible in the cycle following E33.
- `busy` is registered: high from E0+ through E33−, i.e. 33 cycles. It is low in the DONE cycle.
- Back-to-back: `start` in the DONE cycle begins the next operation with no idle gap, giving a throughput of one op per 34 cycles.
- Operands A, B and op are captured at E0 only. They may change freely afterwards.
- hi/lo are stable at all times except at the E33 write and at MT writes.

## Test plan
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> 34 cycles later `done` pulses with hi=0xFFFF_FFFE, lo=0x0000_0001; `busy` high for exactly 33 cycles.
- MULT A=−7 (0xFFFF_FFF9), B=6 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFD6 (−42).
- DIV A=−7, B=2 -> lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIVU A=100, B=7 -> lo=14, hi=2.
- DIVU A=0x1234, B=0 -> lo=0xFFFF_FFFF, hi=0x1234. DIV 0x8000_0000 / −1 -> lo=0x8000_0000, hi=0.
- MTHI 0xAAAA_5555 while busy -> ignored and hi shows the operation result. In IDLE, MTLO 0x5A5A -> lo=0x5A5A next cycle, `done` stays 0.
- Deassert `rst_n` at iteration 10 of a DIVU -> hi=lo=0 and `busy` = 0 asynchronously. After release, issue `start` in a DONE cycle back-to-back -> second result correct 34 cycles after the first.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO: 32 shift-add or restoring steps, then a sign-fix cycle.
// Result visible 34 cycles after the start edge; busy stalls the datapath and start is ignored while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]       acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]       acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [WIDTH-1:0]       a_raw_q, a_raw_d;
  logic                   is_div_q, is_div_d;
  logic                   dz_q, dz_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         add_sum;
  logic [WIDTH:0]         shifted;
  logic [WIDTH-1:0]       diff;
  logic                   borrow;
  logic [2*WIDTH-1:0]     prod, prod_neg;

  always_comb begin
    a_mag    = (op[0] && A[WIDTH-1]) ? -A : A;
    b_mag    = (op[0] && B[WIDTH-1]) ? -B : B;
    add_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    shifted  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    borrow   = shifted < {1'b0, opnd_q};
    // No borrow means the true difference fits in WIDTH bits, so the truncated subtract is exact.
    diff     = shifted[WIDTH-1:0] - opnd_q;
    prod     = {acc_hi_q, acc_lo_q};
    prod_neg = -prod;

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_quo_d = op[0] & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_rem_d = op[0] & A[WIDTH-1];
          dz_d      = (B == '0);
          a_raw_d   = A;
          acc_hi_d  = '0;
          acc_lo_d  = op[1] ? a_mag : b_mag;
          opnd_d    = op[1] ? b_mag : a_mag;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          acc_hi_d = borrow ? shifted[WIDTH-1:0] : diff;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~borrow};
        end else begin
          acc_hi_d = add_sum[WIDTH:1];
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_quo_q ? prod_neg : prod;
        end else if (dz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_quo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases plus random ops against a plain-arithmetic model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi, exp_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Architectural result {hi, lo} computed directly from the instruction semantics.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
    endcase
  endfunction

  // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit mt_busy);
    logic [63:0] e;
    int bcnt, dcnt;
    e = model(o, a, b);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clk);
      bcnt += int'(busy);
      dcnt += int'(done);
      if (mt_busy && i == 5) begin
        mthi = 1'b1; wdata = 32'hAAAA_5555;
      end else begin
        mthi = 1'b0;
      end
    end
    @(negedge clk);
    mthi = 1'b0;
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    chk("busy_cycles", 64'(bcnt), 64'd33);
    chk("done_early", 64'(dcnt), 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("busy_in_done", {63'd0, busy}, 64'd0);
    chk("result", {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int dcnt;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; A = '0; B = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd1, 32'hFFFF_FFF9, 32'd6, 1'b0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd100, 32'd7, 1'b0);
    chk("divu_small", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd2, 32'h1234, 32'd0, 1'b0);
    chk("divu_by_zero", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_overflow", {hi, lo}, {32'h0, 32'h8000_0000});
    run_op(2'd3, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op(2'd1, 32'h0000_1000, 32'h0000_2000, 1'b1);

    // MTLO while idle
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h0000_5A5A;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_idle_lo", {32'd0, lo}, {32'd0, 32'h0000_5A5A});
    chk("mtlo_idle_hi", {32'd0, hi}, {32'd0, exp_hi});
    chk("mtlo_no_done", {63'd0, done}, 64'd0);
    exp_lo = 32'h0000_5A5A;

    // Random ops, mostly back-to-back, with small and zero divisors mixed in.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = rb & 32'hFF;
        2: rb = -(rb & 32'hF);
        3: ra = ra & 32'hFFFF;
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Asynchronous reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = 2'd2; A = 32'hDEAD_BEEF; B = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dcnt += int'(done) + int'(busy);
    end
    chk("no_resume", 64'(dcnt), 64'd0);
    chk("hilo_after_arst", {hi, lo}, 64'd0);

    run_op(2'd2, 32'd1000, 32'd33, 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("b2b_mult_min", {hi, lo}, 64'h4000_0000_0000_0000);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
